// File: rtl/dmem_store_buffer.sv
// Store buffer between the core and data memory: stores retire into a small FIFO
// and drain in order, loads bypass the FIFO unless they hit a buffered word.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] c_addr,
   input  logic          c_r_enable,
   input  logic          c_w_enable,
   input  logic [1:0]    c_w_size,
   input  logic [DW-1:0] c_w_data,
   output logic [DW-1:0] c_r_data,
   output logic          c_ready,
   output logic [AW-1:0] m_addr,
   output logic          m_r_enable,
   output logic          m_w_enable,
   output logic [1:0]    m_w_size,
   output logic [DW-1:0] m_w_data,
   input  logic [DW-1:0] m_r_data,
   input  logic          m_ready,
   input  logic          halt_in,
   output logic          halt_out
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [PW:0]   count_reg;
   logic          halt_pending_reg, halt_out_reg;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [1:0]    size_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];

   logic [DEPTH-1:0] match_vec;
   logic             hazard, core_block, load_req, push, pop, read_done;

   // A slot is live when its distance from the head is below the occupancy.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [PW-1:0] offset;
         assign offset = PW'(gi) - rd_ptr_reg;
         assign match_vec[gi] = ({1'b0, offset} < count_reg) &&
                                (addr_mem[gi][AW-1:2] == c_addr[AW-1:2]);
      end
   endgenerate

   assign hazard     = |match_vec;
   assign core_block = halt_pending_reg | halt_in;
   assign load_req   = c_r_enable & ~c_w_enable & ~core_block;
   assign push       = reset & c_w_enable & ~core_block & (count_reg < FULL);
   assign pop        = (state_reg == DRAIN) & m_ready;
   assign read_done  = (state_reg == READ) & m_ready;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (load_req && !hazard) begin
               state_next = READ;
            end else if (count_reg != '0) begin
               state_next = DRAIN;
            end
         end
         DRAIN:   if (m_ready) state_next = IDLE;
         READ:    if (m_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      m_addr     = '0;
      m_r_enable = 1'b0;
      m_w_enable = 1'b0;
      m_w_size   = 2'b00;
      m_w_data   = '0;
      c_r_data   = '0;
      case (state_reg)
         DRAIN: begin
            m_w_enable = 1'b1;
            m_addr     = addr_mem[rd_ptr_reg];
            m_w_size   = size_mem[rd_ptr_reg];
            m_w_data   = data_mem[rd_ptr_reg];
         end
         READ: begin
            m_r_enable = 1'b1;
            m_addr     = c_addr;
            if (m_ready) c_r_data = m_r_data;
         end
         default: ;
      endcase
      // reset gating keeps c_ready quiet while the array is held empty
      c_ready  = reset & (push | read_done);
      halt_out = halt_out_reg |
                 (halt_pending_reg && (count_reg == '0) && (state_reg == IDLE));
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= c_addr;
         size_mem[wr_ptr_reg] <= c_w_size;
         data_mem[wr_ptr_reg] <= c_w_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         rd_ptr_reg       <= '0;
         wr_ptr_reg       <= '0;
         count_reg        <= '0;
         halt_pending_reg <= 1'b0;
         halt_out_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         halt_pending_reg <= halt_pending_reg | halt_in;
         halt_out_reg     <= halt_out;
      end
   end

endmodule
